note_key_tx: RTL and testbench

NOTE_KEY_TX -- requirements
Module: note_key_tx

---
 rtl/note_key_tx.sv | 201 ++++++++++++++++++++
 tb/tb_note_key_tx.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/note_key_tx.sv
// note_key_tx: turns key press events on 12 note lines into UART 8N1 letters.
// Optional release events (uppercase letters) when NOTE_KEY_TX_RELEASE_EN is defined.
module note_key_tx #(
  parameter int C_CLK_FRQ = 100000000,
  parameter int C_BAUD    = 115200
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] inNote,
  output logic        outTx,
  output logic        outBusy,
  output logic [11:0] outPending
);

  localparam int DIV = C_CLK_FRQ / C_BAUD;
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_e;

  function automatic logic [7:0] key_code(input logic [3:0] idx);
    unique case (idx)
      4'd0:    key_code = 8'h7A;
      4'd1:    key_code = 8'h73;
      4'd2:    key_code = 8'h78;
      4'd3:    key_code = 8'h64;
      4'd4:    key_code = 8'h63;
      4'd5:    key_code = 8'h76;
      4'd6:    key_code = 8'h67;
      4'd7:    key_code = 8'h62;
      4'd8:    key_code = 8'h68;
      4'd9:    key_code = 8'h6E;
      4'd10:   key_code = 8'h6A;
      4'd11:   key_code = 8'h6D;
      default: key_code = 8'h00;
    endcase
  endfunction

  logic [11:0] sync1_q, sync1_d;
  logic [11:0] sync2_q, sync2_d;
  logic [11:0] edge_q, edge_d;
  logic [11:0] pend_q, pend_d;
  logic [11:0] press;
  logic [11:0] clr;
  state_e      state_q, state_d;
  logic [CW-1:0] baud_q, baud_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  shift_q, shift_d;
  logic        sel_any;
  logic [3:0]  sel_idx;
  logic        baud_end;
`ifdef NOTE_KEY_TX_RELEASE_EN
  logic [11:0] rel_q, rel_d;
  logic [11:0] rel_clr;
  logic [11:0] fall;
  logic        sel_rel;
`endif

  // Synchronizer, edge detect and pending-event bookkeeping
  always_comb begin
    sync1_d = inNote;
    sync2_d = sync1_q;
    edge_d  = sync2_q;
    press   = sync2_q & ~edge_q;
    pend_d  = (pend_q & ~clr) | press;
`ifdef NOTE_KEY_TX_RELEASE_EN
    fall    = ~sync2_q & edge_q;
    rel_d   = (rel_q & ~rel_clr) | fall;
`endif
  end

  // Lowest-index pending event; presses outrank releases
  always_comb begin
    sel_any = 1'b0;
    sel_idx = 4'd0;
    for (int i = 11; i >= 0; i--) begin
      if (pend_q[i]) begin
        sel_any = 1'b1;
        sel_idx = 4'(i);
      end
    end
`ifdef NOTE_KEY_TX_RELEASE_EN
    sel_rel = 1'b0;
    if (!sel_any) begin
      for (int i = 11; i >= 0; i--) begin
        if (rel_q[i]) begin
          sel_any = 1'b1;
          sel_rel = 1'b1;
          sel_idx = 4'(i);
        end
      end
    end
`endif
  end

  // Frame sequencer: next state, counters and line outputs
  always_comb begin
    state_d  = state_q;
    baud_d   = baud_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    clr      = '0;
    outTx    = 1'b1;
    outBusy  = 1'b0;
    baud_end = (baud_q == LAST);
`ifdef NOTE_KEY_TX_RELEASE_EN
    rel_clr  = '0;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (sel_any) begin
          shift_d = key_code(sel_idx);
          clr     = 12'd1 << sel_idx;
`ifdef NOTE_KEY_TX_RELEASE_EN
          if (sel_rel) begin
            clr     = '0;
            rel_clr = 12'd1 << sel_idx;
            shift_d = key_code(sel_idx) - 8'h20;
          end
`endif
          baud_d  = '0;
          bit_d   = '0;
          state_d = S_START;
        end
      end
      S_START: begin
        outTx   = 1'b0;
        outBusy = 1'b1;
        if (baud_end) begin
          baud_d  = '0;
          state_d = S_DATA;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      S_DATA: begin
        outTx   = shift_q[0];
        outBusy = 1'b1;
        if (baud_end) begin
          baud_d  = '0;
          shift_d = shift_q >> 1;
          if (bit_q == 3'd7) begin
            bit_d   = '0;
            state_d = S_STOP;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      S_STOP: begin
        outBusy = 1'b1;
        if (baud_end) begin
          baud_d  = '0;
          state_d = S_IDLE;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign outPending = pend_q;

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
      edge_q  <= '0;
      pend_q  <= '0;
      state_q <= S_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
`ifdef NOTE_KEY_TX_RELEASE_EN
      rel_q   <= '0;
`endif
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      edge_q  <= edge_d;
      pend_q  <= pend_d;
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
`ifdef NOTE_KEY_TX_RELEASE_EN
      rel_q   <= rel_d;
`endif
    end
  end

endmodule

// File: tb/tb_note_key_tx.sv
// tb_note_key_tx: directed and random key events, UART decoded by a line monitor
// and compared against an event-order model of the expected letters.
module tb_note_key_tx;

  localparam int FRQ  = 1050;
  localparam int BAUD = 100;
  localparam int DIV  = FRQ / BAUD;
  localparam int DRAIN_MAX = 30 * 11 * DIV;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [11:0] in_note = '0;
  logic        tx;
  logic        busy;
  logic [11:0] pend;

  int errs = 0;
  int checks = 0;

  logic [7:0] codes [12] = '{8'h7A, 8'h73, 8'h78, 8'h64, 8'h63, 8'h76,
                             8'h67, 8'h62, 8'h68, 8'h6E, 8'h6A, 8'h6D};
  logic [7:0] exp_q[$];
  logic [7:0] rx_q[$];

  note_key_tx #(.C_CLK_FRQ(FRQ), .C_BAUD(BAUD)) dut (
    .clk(clk),
    .rst(rst),
    .inNote(in_note),
    .outTx(tx),
    .outBusy(busy),
    .outPending(pend)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // UART line monitor: samples mid-bit and checks frame shape
  int   t = 0;
  bit   act = 0;
  int   brun = 0;
  logic [7:0] rb = '0;
  always @(negedge clk) begin
    if (rst) begin
      act  = 0;
      brun = 0;
    end else begin
      if (busy) brun++;
      else if (brun > 0) begin
        chk("busy_len", brun, 10 * DIV);
        brun = 0;
      end
      if (!act && tx == 1'b0) begin
        act = 1;
        t = 0;
      end
      if (act) begin
        if (t % DIV == DIV / 2) chk("busy_in_frame", busy, 1);
        if (t == DIV / 2) chk("start_bit", tx, 0);
        else if (t > DIV / 2 && t < 9 * DIV && (t % DIV) == DIV / 2)
          rb[t / DIV - 1] = tx;
        else if (t == 9 * DIV + DIV / 2) begin
          chk("stop_bit", tx, 1);
          rx_q.push_back(rb);
        end
        if (t == 10 * DIV - 1) act = 0;
        else t++;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push_press(input logic [11:0] m);
    for (int i = 0; i < 12; i++)
      if (m[i]) exp_q.push_back(codes[i]);
  endtask

  task automatic push_rel(input logic [11:0] m);
`ifdef NOTE_KEY_TX_RELEASE_EN
    for (int i = 0; i < 12; i++)
      if (m[i]) exp_q.push_back(codes[i] - 8'h20);
`else
    if (m != 0) exp_q.push_back(8'h00);
    if (m != 0) void'(exp_q.pop_back());
`endif
  endtask

  task automatic drain(input string tag);
    int quiet;
    int n;
    quiet = 0;
    n = 0;
    tick(5);
    while (quiet < 3 && n < DRAIN_MAX) begin
      @(negedge clk);
      n++;
      if (!busy && pend == 12'h000) quiet++;
      else quiet = 0;
    end
    chk({tag, "_drain"}, quiet >= 3, 1);
  endtask

  task automatic cmp_frames(input string tag);
    int n;
    chk({tag, "_count"}, rx_q.size(), exp_q.size());
    n = (rx_q.size() < exp_q.size()) ? rx_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) chk({tag, "_byte"}, rx_q[i], exp_q[i]);
    rx_q.delete();
    exp_q.delete();
  endtask

  task automatic wait_busy(input string tag);
    int n;
    n = 0;
    while (!busy && n < 20 * DIV) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_busy"}, busy, 1);
  endtask

  task automatic press_release(input string tag, input logic [11:0] m);
    in_note = m;
    push_press(m);
    drain(tag);
    in_note = '0;
    push_rel(m);
    drain(tag);
    cmp_frames(tag);
  endtask

  initial begin
    int n;
    int lows;
    bit found;
    logic [11:0] m;

    // reset state
    rst = 1'b1;
    tick(3);
    chk("rst_tx", tx, 1);
    chk("rst_busy", busy, 0);
    chk("rst_pend", pend, 0);
    rst = 1'b0;
    tick(2);

    // single press: latency and pending timing
    in_note = 12'h001;
    n = 0;
    found = 0;
    while (!found && n < 20) begin
      @(negedge clk);
      n++;
      if (n == 3) chk("z_pend_set", pend, 12'h001);
      if (tx == 1'b0) found = 1;
    end
    chk("z_latency", n, 4);
    chk("z_busy", busy, 1);
    chk("z_pend_clr", pend, 0);
    push_press(12'h001);
    drain("z");
    in_note = '0;
    push_rel(12'h001);
    drain("z_rel");
    cmp_frames("z");

    // two simultaneous presses, one idle cycle between frames
    in_note = 12'h810;
    n = 0;
    while (pend == 12'h000 && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("two_pend0", pend, 12'h810);
    tick(1);
    chk("two_pend1", pend, 12'h800);
    chk("two_busy", busy, 1);
    n = 0;
    while (busy && n < 20 * DIV) begin
      @(negedge clk);
      n++;
    end
    lows = 0;
    while (!busy && lows < 20) begin
      lows++;
      @(negedge clk);
    end
    chk("two_gap", lows, 1);
    chk("two_pend2", pend, 12'h000);
    push_press(12'h810);
    drain("two");
    in_note = '0;
    push_rel(12'h810);
    drain("two_rel");
    cmp_frames("two");

    // repeated presses while pending coalesce
    in_note = 12'h004;
    wait_busy("coal");
    tick(DIV);
    repeat (3) begin
      in_note = 12'h024;
      tick(3);
      in_note = 12'h004;
      tick(3);
    end
    chk("coal_still_busy", busy, 1);
    exp_q.push_back(8'h78);
    exp_q.push_back(8'h76);
    push_rel(12'h020);
    drain("coal");
    in_note = '0;
    push_rel(12'h004);
    drain("coal_rel");
    cmp_frames("coal");

    // press then release of bit9
    press_release("n", 12'h200);

    // reset aborts a frame mid-data
    in_note = 12'h080;
    wait_busy("abort");
    tick(3 * DIV + 2);
    rst = 1'b1;
    tick(1);
    chk("abort_tx", tx, 1);
    chk("abort_busy", busy, 0);
    in_note = '0;
    tick(3);
    chk("abort_pend", pend, 0);
    rst = 1'b0;
    tick(20 * DIV);
    cmp_frames("abort");

    // all keys held through reset release
    rst = 1'b1;
    in_note = 12'hFFF;
    tick(3);
    rst = 1'b0;
    tick(2);
    chk("all_pend_early", pend, 12'h000);
    tick(1);
    chk("all_pend", pend, 12'hFFF);
    push_press(12'hFFF);
    drain("all");
    in_note = '0;
    push_rel(12'hFFF);
    drain("all_rel");
    cmp_frames("all");

    // random multi-hot patterns
    repeat (4) begin
      m = 12'($urandom_range(1, 4095));
      press_release("rnd", m);
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
